// File: rtl/prog_encoder_pkg.sv
// Shared types and field constants for the instruction encoder / program loader.
package prog_encoder_pkg;

    typedef enum logic [2:0] {
        OP_LD  = 3'd0,
        OP_SD  = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_ADD = 3'd4,
        OP_SUB = 3'd5,
        OP_BEQ = 3'd6,
        OP_BLT = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_LDSD = 3'b011;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BLT  = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // beq x0, x0, 0: spins in place once the core reaches it
    localparam logic [31:0] HALT_WORD = 32'h0000_0063;

    // Concatenate the six decoder fields, MSB to LSB
    function automatic logic [31:0] pack_word(
        input logic [6:0] f7,
        input logic [4:0] hi,
        input logic [4:0] rs1,
        input logic [2:0] f3,
        input logic [4:0] lo,
        input logic [6:0] opc
    );
        return {f7, hi, rs1, f3, lo, opc};
    endfunction

endpackage

// File: rtl/prog_encoder_inst_pack.sv
// Combinational packer: symbolic op plus register/immediate fields into a 32-bit word.
module inst_pack
    import prog_encoder_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  imm,
    input  logic        dir,
    output logic [31:0] word
);

    op_e op_s;
    assign op_s = op_e'(op);

    // Select field placement per op; loads and stores reuse rs2/rd slots for the address
    always_comb begin
        word = 32'h0000_0000;
        case (op_s)
            OP_LD:   word = pack_word(F7_BASE, imm, rs1, F3_LDSD, rd,  OPC_LOAD);
            OP_SD:   word = pack_word(F7_BASE, rs2, rs1, F3_LDSD, imm, OPC_STORE);
            OP_AND:  word = pack_word(F7_BASE, rs2, rs1, F3_AND,  rd,  OPC_RTYPE);
            OP_OR:   word = pack_word(F7_BASE, rs2, rs1, F3_OR,   rd,  OPC_RTYPE);
            OP_ADD:  word = pack_word(F7_BASE, rs2, rs1, F3_ADD,  rd,  OPC_RTYPE);
            OP_SUB:  word = pack_word(F7_SUB,  rs2, rs1, F3_ADD,  rd,  OPC_RTYPE);
            OP_BEQ:  word = pack_word({6'b000000, dir}, rs2, rs1, F3_BEQ, imm, OPC_BRANCH);
            OP_BLT:  word = pack_word({6'b000000, dir}, rs2, rs1, F3_BLT, imm, OPC_BRANCH);
            default: word = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/prog_encoder.sv
// Program loader: encodes a stream of symbolic instructions into sequential imem writes.
// Define ENCODER_HALT_EN to append a self-branch halt word after every program.
module prog_encoder
    import prog_encoder_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_imm,
    input  logic              in_dir,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
);

    // Counter is one bit wider than the address so it can reach DEPTH itself
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
`ifdef ENCODER_HALT_EN
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
`endif

    state_e              state_r;
    logic [ADDR_W:0]     cnt_r;
    logic                imem_we_r;
    logic [ADDR_W-1:0]   imem_addr_r;
    logic [31:0]         imem_wdata_r;
    logic                done_r;
    logic                overflow_r;
    logic [31:0]         word_s;
`ifdef ENCODER_HALT_EN
    logic                halt_pend_r;
`endif

    inst_pack u_pack (
        .op   (in_op),
        .rd   (in_rd),
        .rs1  (in_rs1),
        .rs2  (in_rs2),
        .imm  (in_imm),
        .dir  (in_dir),
        .word (word_s)
    );

    // Load sequencer: accept, write one cycle later, track capacity and completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'h0000_0000;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
`ifdef ENCODER_HALT_EN
            halt_pend_r  <= 1'b0;
`endif
        end else begin
            imem_we_r <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r    <= ST_STREAM;
                        cnt_r      <= '0;
                        overflow_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_STREAM: begin
                    if (in_valid) begin
                        imem_we_r    <= 1'b1;
                        imem_addr_r  <= cnt_r[ADDR_W-1:0];
                        imem_wdata_r <= word_s;
                        cnt_r        <= cnt_r + (ADDR_W+1)'(1);
                        if (in_last) begin
                            state_r <= ST_FLUSH;
`ifdef ENCODER_HALT_EN
                            halt_pend_r <= 1'b1;
`endif
                        end else if (cnt_r == LAST_ADDR) begin
                            state_r    <= ST_ERR;
                            overflow_r <= 1'b1;
                        end else begin
                            state_r <= ST_STREAM;
                        end
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_FLUSH: begin
`ifdef ENCODER_HALT_EN
                    if (halt_pend_r) begin
                        halt_pend_r <= 1'b0;
                        if (cnt_r == FULL_CNT) begin
                            state_r    <= ST_ERR;
                            overflow_r <= 1'b1;
                        end else begin
                            imem_we_r    <= 1'b1;
                            imem_addr_r  <= cnt_r[ADDR_W-1:0];
                            imem_wdata_r <= HALT_WORD;
                            cnt_r        <= cnt_r + (ADDR_W+1)'(1);
                        end
                    end else begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
`else
                    state_r <= ST_DONE;
                    done_r  <= 1'b1;
`endif
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_r == ST_STREAM);
    assign busy       = (state_r == ST_STREAM) || (state_r == ST_FLUSH);
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign done       = done_r;
    assign overflow   = overflow_r;
    assign word_count = cnt_r;

endmodule

// File: doc/prog_encoder.md
Name: prog_encoder

Overview:
- Instruction encoder and program loader, the write-side counterpart of the core's instruction decoder.
- Accepts symbolic instructions over a valid/ready stream and packs each into a 32-bit word using the decoder's field layout.
- Writes the words sequentially into instruction memory through a simple write port.
- Used by the testbench/boot path to load programs before the core runs.

Parameters:
- ADDR_W, 6: instruction memory address width.
- DEPTH, 64: number of memory words; must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a new program load at address 0.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept.
- in_op  in  3  op_e: LD, SD, AND, OR, ADD, SUB, BEQ, BLT.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_imm  in  5  LD data address / SD data address / branch offset.
- in_dir  in  1  branch direction (bit 25).
- in_last  in  1  final instruction of the program.
- imem_we  out  1  memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded word.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the load completes.
- overflow  out  1  sticky; program exceeded DEPTH.
- word_count  out  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset values: all outputs 0; state IDLE; address counter 0.
- FSM states: IDLE, STREAM, FLUSH, DONE, ERR.
  - IDLE/DONE/ERR + start → STREAM; clears addr, word_count, overflow. start is ignored in STREAM/FLUSH.
  - in_ready = (state==STREAM).
  - A handshake is accepted when in_valid && in_ready.
- Encoding, {func7, rs2/imm, rs1, func3, rd/imm, opcode}:
  - LD: f3 011, opc 0000011, [24:20]=imm, [19:15]=rs1, [11:7]=rd.
  - SD: f3 011, opc 0100011, [24:20]=rs2, [19:15]=rs1, [11:7]=imm.
  - AND/OR/ADD: f3 111/110/000, opc 0110011, func7 0.
  - SUB: f3 000, opc 0110011, func7 0100000.
  - BEQ/BLT: f3 000/100, opc 1100011, [25]=dir, [31:26]=0, [11:7]=imm, rs1/rs2 placed normally.
  - All unused bits are 0.
- Write timing: latency 1. An accept in cycle N drives imem_we=1 with imem_addr=addr and imem_wdata=word in cycle N+1. addr and word_count increment with each write. imem_we is held for exactly one cycle per word.
- in_last accepted → FLUSH (the final write issues) → DONE, with done pulsed in the cycle of entering DONE. busy=1 in STREAM and FLUSH.
- Capacity: an accept when addr == DEPTH-1 without in_last → ERR after that write; overflow=1, no further writes. An accept at DEPTH-1 with in_last completes normally.
- in_valid while not ready: the fields are held by the source. The encoder drops nothing and never double-writes.
- Reset mid-load: immediate return to IDLE. Words already written remain in memory; word_count clears.

Optional Feature:
- ENCODER_HALT_EN:
  - Defined: after the last program word, FLUSH issues one extra write of halt word 0x00000063 (beq x0,x0,0) at the next address, and word_count includes it. If the last word lands at DEPTH-1, the halt cannot fit → ERR with overflow.
  - Undefined: no halt word is written.

Decomposition:
- Shared package additions:
  - op_e enum.
  - Opcode constants: OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_BRANCH.
  - func3/func7 constants.
  - HALT_WORD.
  - fsm state typedef.
- Sub-module: inst_pack, a combinational op+fields → 32-bit word, reusable by the testbench golden model.

Test Plan:
- start; add rd3 rs1 1 rs2 2 with in_last → one cycle later imem_we=1, addr 0, wdata 0x002081B3; done pulse; word_count 1.
- Stream sub 5,6,7; ld rd4 imm9 rs1 0; beq rs1 1 rs2 2 dir1 imm4 (last) → writes 0x407302B3@0, 0x00903203@1, 0x02208263@2.
- in_valid toggled every other cycle → only accepted beats are written, with contiguous addresses and no duplicates.
- DEPTH=4, five instructions without last → 4 writes, then ERR; overflow=1, in_ready=0; a new start clears overflow.
- rst_n low during STREAM after 2 writes → outputs 0 asynchronously; after release, state IDLE and in_ready=0.
- ENCODER_HALT_EN, single add as last → writes 0x002081B3@0, then 0x00000063@1; word_count 2.
